wash_phase_monitor: RTL and testbench
=====================================

Name: wash_phase_monitor

Overview:
- Receiving end of the 3-bit washer operation-code interface: samples the phase code that the cycle sequencer drives each clock.
- Checks phase order and minimum dwell times, then decodes legal phases into registered actuator enables.
- Sits between the sequencer and the machine's actuator drivers. Latches faults and forces actuators safe until software clears them.

Parameters:
- MIN_START, 4: minimum cycles the STARTED phase (3'b000) must be held before it advances.
- MIN_WASH, 11: minimum cycles for WASHING (3'b001).
- MIN_SPIN, 6: minimum cycles for SPINNING (3'b010).
- MIN_DRY, 6: minimum cycles for DRYING (3'b011).
- MIN_FIN, 4: minimum cycles for FINISHED (3'b100).
- MIN_HALT, 2: minimum cycles for HALT (3'b101).
- CNT_W, 5: dwell counter width. The counter saturates at all-ones.
- MAX_DWELL, 24: watchdog limit in cycles per phase. Used only with WASH_MON_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- op_in  in  3  operation code from the sequencer.
- op_valid  in  1  op_in is meaningful this cycle. When low, the sample is ignored and the dwell counter holds.
- clr_err  in  1  single-cycle pulse: clears sticky errors and leaves FAULT.
- phase  out  3  last accepted phase code.
- motor_en  out  1  drum motor on (WASHING, SPINNING).
- spin_hi  out  1  high-speed spin (SPINNING only).
- water_valve  out  1  fill valve (WASHING only).
- heater  out  1  dryer heater (DRYING only).
- buzzer  out  1  end-of-cycle alert (FINISHED only).
- cycle_done  out  1  one-cycle pulse when HALT->STARTED is accepted.
- cycles_completed  out  8  count of cycle_done pulses; wraps 255->0.
- err_order, err_short, err_code, err_timeout  out  1 each  sticky fault flags.

Behaviour:
- Reset values: phase=3'b000, all actuator outputs 0, cycle_done 0, cycles_completed 0, all error flags 0, FSM=IDLE, dwell counter 0.
- Dwell counter: cleared to 1 when a phase is accepted. Otherwise increments on each cycle with op_valid=1 and op_in==phase, saturating at 2^CNT_W-1.
- FSM state IDLE:
  - Waits for op_valid with op_in=STARTED.
  - On that sample, accepts STARTED and moves to TRACK.
  - Any other valid code in IDLE is ignored; this is the power-up sync.
- FSM state TRACK, on each valid sample:
  - op_in==phase: stay; counter counts.
  - op_in = 6 or 7: err_code=1, go to FAULT.
  - op_in is any other code that is not the successor of phase: err_order=1, go to FAULT. The successor order is 000->001->010->011->100->101->000.
  - op_in is the successor but dwell < MIN for the current phase: err_short=1, go to FAULT.
  - Otherwise: accept the new phase. If the transition is 101->000, pulse cycle_done and increment cycles_completed.
- FSM state FAULT:
  - All actuator outputs forced to 0; phase holds its last accepted value.
  - Stays in FAULT until clr_err=1, then clears all error flags and goes to IDLE.
- clr_err outside FAULT clears the error flags only; the FSM state is unchanged.
- Simultaneous error conditions: err_code takes priority over err_order, which takes priority over err_short. Only one flag is set per event.
- Latency: actuator outputs and phase are registered and reflect an accepted code 1 cycle after the sampling edge. Fault forcing is also registered: outputs go low 1 cycle after the offending sample.
- Decode is a function of the registered phase and FSM state only; there is no combinational path from op_in to any output.
- Reset mid-cycle returns everything to reset values immediately. After release, the block resyncs on the next STARTED.

Optional Feature:
- WASH_MON_TIMEOUT_EN defined: in TRACK, if the dwell counter reaches MAX_DWELL in any phase other than HALT, err_timeout=1 and the FSM goes to FAULT.
- MAX_DWELL must be at most 2^CNT_W-1.
- Not defined: err_timeout is tied to 0 and no watchdog logic is built.

Test Plan:
- Reset release, then a legal sequence with each phase held exactly its MIN cycles -> outputs decode correctly one cycle late; cycle_done pulses once; cycles_completed=1; no errors.
- In TRACK, WASHING held 10 cycles then SPINNING -> err_short=1, all actuators 0 next cycle; clr_err -> IDLE; a following STARTED resyncs.
- In TRACK, WASHING->DRYING (skips SPINNING) -> err_order=1; op_in=3'b111 in a separate run -> err_code=1 only.
- op_valid deasserted for 5 cycles mid-WASHING -> dwell counter frozen; 11 valid cycles still required before SPINNING is accepted.
- 256 legal full cycles -> cycles_completed wraps to 0; 256 cycle_done pulses counted.
- With WASH_MON_TIMEOUT_EN: DRYING held 24 cycles -> err_timeout=1 and FAULT. Without the macro, the same stimulus gives no error.

Source files
------------

// File: rtl/wash_phase_monitor_if.sv
// Washer operation-code bus between the cycle sequencer (master) and the
// phase monitor (slave). Carries the sampled phase code, the software
// error-clear pulse, and the monitor's decoded actuator/status outputs.
interface wash_phase_monitor_if;
  logic [2:0] op_in;
  logic       op_valid;
  logic       clr_err;
  logic [2:0] phase;
  logic       motor_en;
  logic       spin_hi;
  logic       water_valve;
  logic       heater;
  logic       buzzer;
  logic       cycle_done;
  logic [7:0] cycles_completed;
  logic       err_order;
  logic       err_short;
  logic       err_code;
  logic       err_timeout;

  modport master (
    output op_in, op_valid, clr_err,
    input  phase, motor_en, spin_hi, water_valve, heater, buzzer,
    input  cycle_done, cycles_completed,
    input  err_order, err_short, err_code, err_timeout
  );

  modport slave (
    input  op_in, op_valid, clr_err,
    output phase, motor_en, spin_hi, water_valve, heater, buzzer,
    output cycle_done, cycles_completed,
    output err_order, err_short, err_code, err_timeout
  );
endinterface

// File: rtl/wash_phase_monitor.sv
// Washer phase monitor: tracks the sequencer's 3-bit phase code, enforces
// phase order and minimum dwell per phase, decodes the accepted phase into
// actuator enables and latches sticky faults that force actuators off
// until software pulses clr_err.
// Optional watchdog: define WASH_MON_TIMEOUT_EN to fault when any phase
// other than HALT dwells for MAX_DWELL cycles.
module wash_phase_monitor #(
  parameter int MIN_START = 4,
  parameter int MIN_WASH  = 11,
  parameter int MIN_SPIN  = 6,
  parameter int MIN_DRY   = 6,
  parameter int MIN_FIN   = 4,
  parameter int MIN_HALT  = 2,
  parameter int CNT_W     = 5,
  parameter int MAX_DWELL = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  wash_phase_monitor_if.slave  bus
);

  localparam logic [2:0] PH_START = 3'd0;
  localparam logic [2:0] PH_WASH  = 3'd1;
  localparam logic [2:0] PH_SPIN  = 3'd2;
  localparam logic [2:0] PH_DRY   = 3'd3;
  localparam logic [2:0] PH_FIN   = 3'd4;
  localparam logic [2:0] PH_HALT  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TRACK = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  // The watchdog compares against the dwell counter, so the limit must fit.
  if (MAX_DWELL > (1 << CNT_W) - 1) begin : g_max_dwell_range
    $error("MAX_DWELL does not fit in the CNT_W dwell counter");
  end

  state_t           state_q, state_d;
  logic [2:0]       phase_q, phase_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic             cycle_done_q, cycle_done_d;
  logic [7:0]       cycles_q, cycles_d;
  logic             err_order_q, err_order_d;
  logic             err_short_q, err_short_d;
  logic             err_code_q, err_code_d;
`ifdef WASH_MON_TIMEOUT_EN
  logic             err_timeout_q, err_timeout_d;
`endif

  logic motor_en, spin_hi, water_valve, heater, buzzer;

  function automatic logic [2:0] successor(input logic [2:0] p);
    return (p == PH_HALT) ? PH_START : p + 3'd1;
  endfunction

  function automatic logic [CNT_W-1:0] min_dwell(input logic [2:0] p);
    logic [CNT_W-1:0] m;
    unique case (p)
      PH_START: m = CNT_W'(MIN_START);
      PH_WASH:  m = CNT_W'(MIN_WASH);
      PH_SPIN:  m = CNT_W'(MIN_SPIN);
      PH_DRY:   m = CNT_W'(MIN_DRY);
      PH_FIN:   m = CNT_W'(MIN_FIN);
      default:  m = CNT_W'(MIN_HALT);
    endcase
    return m;
  endfunction

  // Saturating increment so a long-held phase never wraps back below its minimum.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
  endfunction

  // State, phase, dwell, cycle counter and sticky error registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      phase_q       <= PH_START;
      dwell_q       <= '0;
      cycle_done_q  <= 1'b0;
      cycles_q      <= 8'd0;
      err_order_q   <= 1'b0;
      err_short_q   <= 1'b0;
      err_code_q    <= 1'b0;
`ifdef WASH_MON_TIMEOUT_EN
      err_timeout_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      dwell_q       <= dwell_d;
      cycle_done_q  <= cycle_done_d;
      cycles_q      <= cycles_d;
      err_order_q   <= err_order_d;
      err_short_q   <= err_short_d;
      err_code_q    <= err_code_d;
`ifdef WASH_MON_TIMEOUT_EN
      err_timeout_q <= err_timeout_d;
`endif
    end
  end

  // Next-state: resync in IDLE, order/dwell checking in TRACK, hold in FAULT.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    dwell_d      = dwell_q;
    cycle_done_d = 1'b0;
    cycles_d     = cycles_q;
    // clr_err clears flags in any state; a fault raised below still wins.
    err_order_d  = bus.clr_err ? 1'b0 : err_order_q;
    err_short_d  = bus.clr_err ? 1'b0 : err_short_q;
    err_code_d   = bus.clr_err ? 1'b0 : err_code_q;
`ifdef WASH_MON_TIMEOUT_EN
    err_timeout_d = bus.clr_err ? 1'b0 : err_timeout_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (bus.op_valid && bus.op_in == PH_START) begin
          state_d = S_TRACK;
          phase_d = PH_START;
          dwell_d = {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      S_TRACK: begin
        if (bus.op_valid) begin
          if (bus.op_in == phase_q) begin
            dwell_d = sat_inc(dwell_q);
          end else if (bus.op_in > PH_HALT) begin
            err_code_d = 1'b1;
            state_d    = S_FAULT;
          end else if (bus.op_in != successor(phase_q)) begin
            err_order_d = 1'b1;
            state_d     = S_FAULT;
          end else if (dwell_q < min_dwell(phase_q)) begin
            err_short_d = 1'b1;
            state_d     = S_FAULT;
          end else begin
            phase_d = bus.op_in;
            dwell_d = {{(CNT_W-1){1'b0}}, 1'b1};
            if (phase_q == PH_HALT) begin
              cycle_done_d = 1'b1;
              cycles_d     = cycles_q + 8'd1;
            end
          end
        end
`ifdef WASH_MON_TIMEOUT_EN
        // Watchdog trips on the sample that brings the dwell up to the limit.
        if (state_d == S_TRACK && phase_d != PH_HALT &&
            dwell_d >= CNT_W'(MAX_DWELL)) begin
          err_timeout_d = 1'b1;
          state_d       = S_FAULT;
        end
`endif
      end
      S_FAULT: begin
        if (bus.clr_err) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Actuator decode from registered phase; only a tracked phase drives anything.
  always_comb begin
    motor_en    = 1'b0;
    spin_hi     = 1'b0;
    water_valve = 1'b0;
    heater      = 1'b0;
    buzzer      = 1'b0;
    if (state_q == S_TRACK) begin
      unique case (phase_q)
        PH_WASH: begin motor_en = 1'b1; water_valve = 1'b1; end
        PH_SPIN: begin motor_en = 1'b1; spin_hi = 1'b1; end
        PH_DRY:  heater = 1'b1;
        PH_FIN:  buzzer = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.phase            = phase_q;
  assign bus.motor_en         = motor_en;
  assign bus.spin_hi          = spin_hi;
  assign bus.water_valve      = water_valve;
  assign bus.heater           = heater;
  assign bus.buzzer           = buzzer;
  assign bus.cycle_done       = cycle_done_q;
  assign bus.cycles_completed = cycles_q;
  assign bus.err_order        = err_order_q;
  assign bus.err_short        = err_short_q;
  assign bus.err_code         = err_code_q;
`ifdef WASH_MON_TIMEOUT_EN
  assign bus.err_timeout      = err_timeout_q;
`else
  assign bus.err_timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_wash_phase_monitor.sv
// Testbench for wash_phase_monitor: a behavioural reference model predicts
// the full output vector for every driven sample; predictions are queued
// and compared once the DUT has registered that sample.
module tb_wash_phase_monitor;

  logic clk = 1'b0;
  logic rst = 1'b0;

  wash_phase_monitor_if bus();

  wash_phase_monitor dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [2:0] op;
    logic       v;
    logic       clr;
  } stim_t;

  stim_t       stim_q[$];
  logic [20:0] sb_q[$];

  // Reference model state
  int         m_state;   // 0 idle, 1 tracking, 2 fault
  logic [2:0] m_phase;
  int         m_dwell;
  logic [7:0] m_cnt;
  logic       m_done;
  logic       m_eo, m_es, m_ec, m_et;
  int         mins[6] = '{4, 11, 6, 6, 4, 2};

  function automatic logic [20:0] obs_vec();
    return {bus.phase, bus.motor_en, bus.spin_hi, bus.water_valve, bus.heater,
            bus.buzzer, bus.cycle_done, bus.cycles_completed,
            bus.err_order, bus.err_short, bus.err_code, bus.err_timeout};
  endfunction

  function automatic logic [20:0] model_vec();
    logic [4:0] act;  // motor, spin_hi, valve, heater, buzzer
    act = 5'b00000;
    if (m_state == 1) begin
      case (m_phase)
        3'd1: act = 5'b10100;
        3'd2: act = 5'b11000;
        3'd3: act = 5'b00010;
        3'd4: act = 5'b00001;
        default: act = 5'b00000;
      endcase
    end
    return {m_phase, act, m_done, m_cnt, m_eo, m_es, m_ec, m_et};
  endfunction

  function automatic void model_reset();
    m_state = 0; m_phase = 3'd0; m_dwell = 0; m_cnt = 8'd0; m_done = 1'b0;
    m_eo = 1'b0; m_es = 1'b0; m_ec = 1'b0; m_et = 1'b0;
  endfunction

  function automatic void model_step(input logic [2:0] op, input logic v, input logic clr);
    logic [2:0] nxt;
    m_done = 1'b0;
    if (clr) begin m_eo = 1'b0; m_es = 1'b0; m_ec = 1'b0; m_et = 1'b0; end
    nxt = (m_phase == 3'd5) ? 3'd0 : m_phase + 3'd1;
    if (m_state == 0) begin
      if (v && op == 3'd0) begin m_state = 1; m_phase = 3'd0; m_dwell = 1; end
    end else if (m_state == 1) begin
      if (v) begin
        if (op == m_phase)            m_dwell = (m_dwell < 31) ? m_dwell + 1 : 31;
        else if (op >= 3'd6)          begin m_ec = 1'b1; m_state = 2; end
        else if (op != nxt)           begin m_eo = 1'b1; m_state = 2; end
        else if (m_dwell < mins[m_phase]) begin m_es = 1'b1; m_state = 2; end
        else begin
          if (m_phase == 3'd5) begin m_done = 1'b1; m_cnt = m_cnt + 8'd1; end
          m_phase = op;
          m_dwell = 1;
        end
      end
`ifdef WASH_MON_TIMEOUT_EN
      if (m_state == 1 && m_phase != 3'd5 && m_dwell >= 24) begin
        m_et = 1'b1; m_state = 2;
      end
`endif
    end else begin
      if (clr) m_state = 0;
    end
  endfunction

  function automatic void hold(input logic [2:0] op, input int n);
    for (int k = 0; k < n; k++) stim_q.push_back('{op: op, v: 1'b1, clr: 1'b0});
  endfunction

  function automatic void gap(input logic [2:0] op, input int n);
    for (int k = 0; k < n; k++) stim_q.push_back('{op: op, v: 1'b0, clr: 1'b0});
  endfunction

  function automatic void clr_pulse(input logic [2:0] op, input logic v);
    stim_q.push_back('{op: op, v: v, clr: 1'b1});
  endfunction

  // One full legal cycle after STARTED, each phase at its minimum, ending on the next STARTED.
  function automatic void legal_tail();
    hold(3'd1, 11); hold(3'd2, 6); hold(3'd3, 6); hold(3'd4, 4); hold(3'd5, 2);
    hold(3'd0, 4);
  endfunction

  task automatic apply(input logic [2:0] op, input logic v, input logic clr);
    @(negedge clk);
    bus.op_in    = op;
    bus.op_valid = v;
    bus.clr_err  = clr;
    model_step(op, v, clr);
    sb_q.push_back(model_vec());
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.op_in = 3'd0; bus.op_valid = 1'b0; bus.clr_err = 1'b0;
    rst = 1'b0;
    model_reset();
    sb_q.delete();
    stim_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [20:0] got, exp;
    do_reset();
    #1;
    got = obs_vec(); n_checks++;
    if (got !== 21'd0) begin
      n_fail++; $display("FAIL reset_values: got %h expected %h", got, 21'd0);
    end
    // Non-STARTED codes are ignored while syncing, then STARTED and WASHING go through.
    hold(3'd1, 2); hold(3'd7, 1); hold(3'd3, 1); hold(3'd0, 4); hold(3'd1, 3);
    foreach (stim_q[i]) begin
      apply(stim_q[i].op, stim_q[i].v, stim_q[i].clr);
      got = obs_vec(); exp = sb_q.pop_front(); n_checks++;
      if (got !== exp) begin
        n_fail++; $display("FAIL reset_sync[%0d]: got %h expected %h", i, got, exp);
      end
    end
    // Asynchronous reset in mid-WASHING, away from any clock edge.
    #2 rst = 1'b0;
    #1;
    got = obs_vec(); n_checks++;
    if (got !== 21'd0) begin
      n_fail++; $display("FAIL reset_async: got %h expected %h", got, 21'd0);
    end
    model_reset();
    sb_q.delete();
    stim_q.delete();
    @(negedge clk) rst = 1'b1;
  endtask

  task automatic test_legal_sequence();
    logic [20:0] got, exp;
    int pulses = 0;
    do_reset();
    hold(3'd0, 4); legal_tail(); hold(3'd1, 3);
    foreach (stim_q[i]) begin
      apply(stim_q[i].op, stim_q[i].v, stim_q[i].clr);
      if (bus.cycle_done) pulses++;
      got = obs_vec(); exp = sb_q.pop_front(); n_checks++;
      if (got !== exp) begin
        n_fail++; $display("FAIL legal[%0d]: got %h expected %h", i, got, exp);
      end
    end
    n_checks++;
    if (pulses != 1 || bus.cycles_completed !== 8'd1) begin
      n_fail++; $display("FAIL legal_count: got pulses %0d count %0d expected 1 1",
                         pulses, bus.cycles_completed);
    end
  endtask

  task automatic test_short_dwell();
    logic [20:0] got, exp;
    do_reset();
    hold(3'd0, 4); hold(3'd1, 10); hold(3'd2, 1);   // SPINNING one cycle early
    hold(3'd2, 3);                                   // stuck in fault
    clr_pulse(3'd2, 1'b0);                           // clear, back to IDLE
    hold(3'd1, 2);                                   // ignored while resyncing
    hold(3'd0, 4); hold(3'd1, 2);                    // resync
    foreach (stim_q[i]) begin
      apply(stim_q[i].op, stim_q[i].v, stim_q[i].clr);
      got = obs_vec(); exp = sb_q.pop_front(); n_checks++;
      if (got !== exp) begin
        n_fail++; $display("FAIL short[%0d]: got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_order_and_code();
    logic [20:0] got, exp;
    do_reset();
    hold(3'd0, 4); hold(3'd1, 11); hold(3'd3, 2);   // skips SPINNING
    clr_pulse(3'd0, 1'b0);
    hold(3'd0, 4); hold(3'd7, 2);                    // illegal code
    clr_pulse(3'd0, 1'b0);
    hold(3'd0, 2); hold(3'd6, 1);                    // code wins over order/short
    clr_pulse(3'd0, 1'b0);
    hold(3'd0, 2); hold(3'd4, 1);                    // order wins over short
    foreach (stim_q[i]) begin
      apply(stim_q[i].op, stim_q[i].v, stim_q[i].clr);
      got = obs_vec(); exp = sb_q.pop_front(); n_checks++;
      if (got !== exp) begin
        n_fail++; $display("FAIL order_code[%0d]: got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_valid_gap();
    logic [20:0] got, exp;
    do_reset();
    hold(3'd0, 4); hold(3'd1, 6); gap(3'd2, 5); hold(3'd1, 5); hold(3'd2, 2);
    clr_pulse(3'd2, 1'b1);                           // clr in TRACK: no state change
    hold(3'd2, 2);
    do_reset();
    foreach (stim_q[i]) begin end
    hold(3'd0, 4); hold(3'd1, 6); gap(3'd2, 5); hold(3'd1, 4); hold(3'd2, 1);
    foreach (stim_q[i]) begin
      apply(stim_q[i].op, stim_q[i].v, stim_q[i].clr);
      got = obs_vec(); exp = sb_q.pop_front(); n_checks++;
      if (got !== exp) begin
        n_fail++; $display("FAIL gap_short[%0d]: got %h expected %h", i, got, exp);
      end
    end
    do_reset();
    hold(3'd0, 4); hold(3'd1, 6); gap(3'd2, 5); hold(3'd1, 5); hold(3'd2, 2);
    clr_pulse(3'd2, 1'b1);
    hold(3'd2, 2);
    foreach (stim_q[i]) begin
      apply(stim_q[i].op, stim_q[i].v, stim_q[i].clr);
      got = obs_vec(); exp = sb_q.pop_front(); n_checks++;
      if (got !== exp) begin
        n_fail++; $display("FAIL gap_ok[%0d]: got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_back_to_back_wrap();
    logic [20:0] got, exp;
    int pulses = 0;
    do_reset();
    hold(3'd0, 4);
    for (int c = 0; c < 256; c++) legal_tail();
    foreach (stim_q[i]) begin
      apply(stim_q[i].op, stim_q[i].v, stim_q[i].clr);
      if (bus.cycle_done) pulses++;
      got = obs_vec(); exp = sb_q.pop_front(); n_checks++;
      if (got !== exp) begin
        n_fail++; $display("FAIL wrap[%0d]: got %h expected %h", i, got, exp);
      end
    end
    n_checks++;
    if (pulses != 256 || bus.cycles_completed !== 8'd0) begin
      n_fail++; $display("FAIL wrap_count: got pulses %0d count %0d expected 256 0",
                         pulses, bus.cycles_completed);
    end
  endtask

  task automatic test_timeout();
    logic [20:0] got, exp;
    do_reset();
    // DRYING held 24 cycles (watchdog trips only when enabled).
    hold(3'd0, 4); hold(3'd1, 11); hold(3'd2, 6); hold(3'd3, 24); hold(3'd3, 2);
    hold(3'd4, 1);
    do_reset();
    // HALT is exempt and its dwell counter saturates without wrapping.
    hold(3'd0, 4); hold(3'd1, 11); hold(3'd2, 6); hold(3'd3, 6); hold(3'd4, 4);
    hold(3'd5, 40); hold(3'd0, 2);
    foreach (stim_q[i]) begin
      apply(stim_q[i].op, stim_q[i].v, stim_q[i].clr);
      got = obs_vec(); exp = sb_q.pop_front(); n_checks++;
      if (got !== exp) begin
        n_fail++; $display("FAIL halt_sat[%0d]: got %h expected %h", i, got, exp);
      end
    end
    do_reset();
    hold(3'd0, 4); hold(3'd1, 11); hold(3'd2, 6); hold(3'd3, 24); hold(3'd3, 2);
    hold(3'd4, 1);
    foreach (stim_q[i]) begin
      apply(stim_q[i].op, stim_q[i].v, stim_q[i].clr);
      got = obs_vec(); exp = sb_q.pop_front(); n_checks++;
      if (got !== exp) begin
        n_fail++; $display("FAIL timeout[%0d]: got %h expected %h", i, got, exp);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "time limit");
  end

  initial begin
    bus.op_in    = 3'd0;
    bus.op_valid = 1'b0;
    bus.clr_err  = 1'b0;
    model_reset();
    test_reset();
    test_legal_sequence();
    test_short_dwell();
    test_order_and_code();
    test_valid_gap();
    test_back_to_back_wrap();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
